// File: rtl/lut_cfg_pkg.sv
// lut_cfg_pkg: shared loader FSM states and chain-sizing helpers for the LUT config path
package lut_cfg_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int lut_mem_size(input int ninputs);
    return 1 << ninputs;
  endfunction
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
endpackage

// File: rtl/cfg_word_serializer.sv
// cfg_word_serializer: one-word buffer that presents its chunks LSB first, holding the last chunk when drained
module cfg_word_serializer import lut_cfg_pkg::*; #(
  parameter int WORD_WIDTH = 32,
  parameter int CONFIG_WIDTH = 1
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         load,
  input  logic                                         shift,
  input  logic [WORD_WIDTH-1:0]                        word,
  input  logic [clog2(WORD_WIDTH/CONFIG_WIDTH+1)-1:0]  nchunks,
  output logic [CONFIG_WIDTH-1:0]                      chunk,
  output logic                                         last,
  output logic                                         empty
);
  localparam int NC_W = clog2(WORD_WIDTH / CONFIG_WIDTH + 1);
  logic [WORD_WIDTH-1:0] sr;
  logic [NC_W-1:0] left;
  logic v;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
      left <= '0;
      v <= 1'b0;
    end else if (load) begin
      sr <= word;
      left <= nchunks;
      v <= 1'b1;
    end else if (shift && v) begin
      left <= left - NC_W'(1);
      v <= left != NC_W'(1);
      if (left != NC_W'(1)) sr <= sr >> CONFIG_WIDTH;
    end
  end
  assign chunk = sr[CONFIG_WIDTH-1:0];
  assign last = v && left == NC_W'(1);
  assign empty = !v;
endmodule

// File: rtl/lut_cfg_loader.sv
// lut_cfg_loader: streams bitstream words into the LUT config chain for exactly one full chain load
module lut_cfg_loader import lut_cfg_pkg::*; #(
  parameter int CONFIG_WIDTH = 1,
  parameter int LUT_NINPUTS = 4,
  parameter int NUM_LUTS = 1,
  parameter int WORD_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    word_valid,
  output logic                    word_ready,
  input  logic [WORD_WIDTH-1:0]   word_data,
  output logic [NUM_LUTS-1:0]     config_en,
  output logic [CONFIG_WIDTH-1:0] config_data,
  output logic                    busy,
  output logic                    done
);
  localparam int LUT_MEM_SIZE = lut_mem_size(LUT_NINPUTS);
  localparam int TOTAL_BITS = LUT_MEM_SIZE * NUM_LUTS;
  localparam int SHIFT_CYCLES = TOTAL_BITS / CONFIG_WIDTH;
  localparam int NUM_WORDS = ceil_div(TOTAL_BITS, WORD_WIDTH);
  localparam int CPW = WORD_WIDTH / CONFIG_WIDTH;
  localparam int LAST_CHUNKS = (TOTAL_BITS - (NUM_WORDS - 1) * WORD_WIDTH) / CONFIG_WIDTH;
  localparam int CC_W = clog2(SHIFT_CYCLES + 1);
  localparam int WC_W = clog2(NUM_WORDS + 1);
  localparam int NC_W = clog2(CPW + 1);
  state_t st, nxt;
  logic [CC_W-1:0] chunk_cnt;
  logic [WC_W-1:0] word_cnt;
  logic [NC_W-1:0] nchunks;
  logic empty, last, hs, final_chunk, start_ok;
  assign start_ok = start && (st == IDLE || st == DONE);
  assign word_ready = busy && word_cnt < WC_W'(NUM_WORDS) && (empty || last);
  assign hs = word_valid && word_ready;
  assign final_chunk = !empty && chunk_cnt == CC_W'(SHIFT_CYCLES - 1);
  assign nchunks = word_cnt == WC_W'(NUM_WORDS - 1) ? NC_W'(LAST_CHUNKS) : NC_W'(CPW);
  assign config_en = {NUM_LUTS{!empty}};
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = start ? FETCH : IDLE;
      FETCH:   nxt = hs ? SHIFT : FETCH;
      SHIFT:   nxt = final_chunk ? DONE : (last && !hs ? FETCH : SHIFT);
      DONE:    nxt = start ? FETCH : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      chunk_cnt <= '0;
      word_cnt <= '0;
    end else begin
      st <= nxt;
      busy <= nxt == FETCH || nxt == SHIFT;
      done <= nxt == DONE;
      if (start_ok) begin
        chunk_cnt <= '0;
        word_cnt <= '0;
      end else begin
        if (hs && word_cnt != WC_W'(NUM_WORDS)) word_cnt <= word_cnt + WC_W'(1);
        if (!empty && chunk_cnt != CC_W'(SHIFT_CYCLES)) chunk_cnt <= chunk_cnt + CC_W'(1);
      end
    end
  end
  cfg_word_serializer #(.WORD_WIDTH(WORD_WIDTH), .CONFIG_WIDTH(CONFIG_WIDTH)) u_ser (
    .clk(clk),
    .rst_n(rst_n),
    .load(hs),
    .shift(st == SHIFT),
    .word(word_data),
    .nchunks(nchunks),
    .chunk(config_data),
    .last(last),
    .empty(empty)
  );
endmodule

// File: tb/tb_lut_cfg_loader.sv
// tb_lut_cfg_loader: directed checks of lut_cfg_loader in three chain configurations against a behavioural chain model
module tb_lut_cfg_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_bad = 0;
  logic s0 = 1'b0, wv0 = 1'b0, wr0, busy0, done0, cd0;
  logic [31:0] wd0 = '0;
  logic [0:0] ce0;
  lut_cfg_loader d0 (.clk(clk), .rst_n(rst_n), .start(s0), .word_valid(wv0), .word_ready(wr0),
    .word_data(wd0), .config_en(ce0), .config_data(cd0), .busy(busy0), .done(done0));
  logic s1 = 1'b0, wv1 = 1'b0, wr1, busy1, done1, cd1;
  logic [15:0] wd1 = '0;
  logic [3:0] ce1;
  lut_cfg_loader #(.NUM_LUTS(4), .WORD_WIDTH(16)) d1 (.clk(clk), .rst_n(rst_n), .start(s1),
    .word_valid(wv1), .word_ready(wr1), .word_data(wd1), .config_en(ce1), .config_data(cd1),
    .busy(busy1), .done(done1));
  logic s2 = 1'b0, wv2 = 1'b0, wr2, busy2, done2;
  logic [31:0] wd2 = '0;
  logic [0:0] ce2;
  logic [3:0] cd2;
  lut_cfg_loader #(.CONFIG_WIDTH(4)) d2 (.clk(clk), .rst_n(rst_n), .start(s2), .word_valid(wv2),
    .word_ready(wr2), .word_data(wd2), .config_en(ce2), .config_data(cd2), .busy(busy2), .done(done2));
  logic [15:0] cap0, cap2;
  logic [63:0] cap1;
  always @(posedge clk) begin
    if (ce0[0]) cap0 <= {cd0, cap0[15:1]};
    if (ce1[0]) cap1 <= {cd1, cap1[63:1]};
    if (ce2[0]) cap2 <= {cd2, cap2[15:4]};
  end
  logic [15:0] words [4] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008};
  int hs_n, en_n, done_n, done_at, first_en, last_en, idle_rdy, late_rdy, odd_en, gap_at;
  logic b1, r1, busy_done;
  logic [15:0] seq;
  task automatic run_d0(input logic [31:0] w, input int pre, input bit restart);
    bit taken = 0;
    hs_n = 0; en_n = 0; done_n = 0; done_at = 0; first_en = 0; last_en = 0; idle_rdy = 0;
    seq = '0; busy_done = 1'b1; b1 = 1'b0; r1 = 1'b0;
    wd0 = w;
    wv0 = 1'b1;
    repeat (pre) begin
      @(negedge clk);
      if (wr0) idle_rdy++;
    end
    @(negedge clk);
    s0 = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      s0 = restart && i == 8;
      if (taken) wv0 = 1'b0;
      taken = wv0 && wr0;
      if (taken) hs_n++;
      if (i == 1) begin b1 = busy0; r1 = wr0; end
      if (ce0[0]) begin
        if (en_n < 16) seq[en_n] = cd0;
        en_n++;
        if (first_en == 0) first_en = i;
        last_en = i;
      end
      if (done0) begin done_n++; done_at = i; busy_done = busy0; end
    end
  endtask
  task automatic run_d1(input bit stall);
    bit taken = 0;
    int w = 0;
    hs_n = 0; en_n = 0; done_n = 0; done_at = 0; first_en = 0; last_en = 0; late_rdy = 0;
    odd_en = 0; gap_at = 0;
    @(negedge clk);
    s1 = 1'b1;
    wv1 = 1'b1;
    wd1 = words[0];
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      s1 = 1'b0;
      if (taken) w++;
      wv1 = w < 4 && !(stall && w == 2 && i >= 33 && i <= 37);
      wd1 = words[w < 4 ? w : 3];
      taken = wv1 && wr1;
      if (taken) hs_n++;
      if (w >= 4 && wr1) late_rdy++;
      if (ce1 != 4'h0 && ce1 != 4'hF) odd_en++;
      if (ce1[0]) begin
        if (last_en != 0 && i != last_en + 1 && gap_at == 0) gap_at = last_en + 1;
        if (first_en == 0) first_en = i;
        last_en = i;
        en_n++;
      end
      if (done1) begin done_n++; done_at = i; end
    end
    wv1 = 1'b0;
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (wr0 !== 1'b0) begin n_bad++; $display("FAIL reset.word_ready got=%b exp=0", wr0); end
    n_cmp++; if (ce0 !== 1'b0) begin n_bad++; $display("FAIL reset.config_en got=%b exp=0", ce0); end
    n_cmp++; if (cd0 !== 1'b0) begin n_bad++; $display("FAIL reset.config_data got=%b exp=0", cd0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL reset.busy got=%b exp=0", busy0); end
    n_cmp++; if (done0 !== 1'b0) begin n_bad++; $display("FAIL reset.done got=%b exp=0", done0); end
    n_cmp++; if (ce1 !== 4'h0) begin n_bad++; $display("FAIL reset.config_en_4lut got=%h exp=0", ce1); end
    n_cmp++; if (cd2 !== 4'h0) begin n_bad++; $display("FAIL reset.config_data_cw4 got=%h exp=0", cd2); end
    rst_n = 1'b1;
  endtask
  task automatic test_default();
    logic [15:0] exp_seq = 16'hA5C3;
    run_d0(32'h0000A5C3, 0, 1'b0);
    n_cmp++; if (b1 !== 1'b1) begin n_bad++; $display("FAIL default.busy_cycle1 got=%b exp=1", b1); end
    n_cmp++; if (r1 !== 1'b1) begin n_bad++; $display("FAIL default.ready_cycle1 got=%b exp=1", r1); end
    n_cmp++; if (hs_n != 1) begin n_bad++; $display("FAIL default.handshakes got=%0d exp=1", hs_n); end
    n_cmp++; if (en_n != 16) begin n_bad++; $display("FAIL default.en_cycles got=%0d exp=16", en_n); end
    n_cmp++; if (first_en != 2 || last_en != 17) begin n_bad++; $display("FAIL default.en_window got=%0d..%0d exp=2..17", first_en, last_en); end
    n_cmp++; if (seq !== exp_seq) begin n_bad++; $display("FAIL default.chunk_seq got=%h exp=%h", seq, exp_seq); end
    n_cmp++; if (done_at != 18 || done_n != 1) begin n_bad++; $display("FAIL default.done got=cycle %0d x%0d exp=cycle 18 x1", done_at, done_n); end
    n_cmp++; if (busy_done !== 1'b0) begin n_bad++; $display("FAIL default.busy_in_done got=%b exp=0", busy_done); end
    n_cmp++; if (cap0[0] !== 1'b1) begin n_bad++; $display("FAIL default.lut_addr0 got=%b exp=1", cap0[0]); end
    n_cmp++; if (cap0[2] !== 1'b0) begin n_bad++; $display("FAIL default.lut_addr2 got=%b exp=0", cap0[2]); end
    n_cmp++; if (cap0 !== 16'hA5C3) begin n_bad++; $display("FAIL default.lut_contents got=%h exp=a5c3", cap0); end
  endtask
  task automatic test_back_to_back();
    run_d1(1'b0);
    n_cmp++; if (hs_n != 4) begin n_bad++; $display("FAIL b2b.handshakes got=%0d exp=4", hs_n); end
    n_cmp++; if (en_n != 64) begin n_bad++; $display("FAIL b2b.en_cycles got=%0d exp=64", en_n); end
    n_cmp++; if (first_en != 2 || last_en != 65) begin n_bad++; $display("FAIL b2b.en_window got=%0d..%0d exp=2..65", first_en, last_en); end
    n_cmp++; if (gap_at != 0) begin n_bad++; $display("FAIL b2b.first_gap got=%0d exp=0", gap_at); end
    n_cmp++; if (late_rdy != 0) begin n_bad++; $display("FAIL b2b.ready_after_last got=%0d exp=0", late_rdy); end
    n_cmp++; if (odd_en != 0) begin n_bad++; $display("FAIL b2b.en_bits_unequal got=%0d exp=0", odd_en); end
    n_cmp++; if (done_at != 66 || done_n != 1) begin n_bad++; $display("FAIL b2b.done got=cycle %0d x%0d exp=cycle 66 x1", done_at, done_n); end
    n_cmp++; if (cap1 !== 64'h0008000400020001) begin n_bad++; $display("FAIL b2b.lut_contents got=%h exp=0008000400020001", cap1); end
  endtask
  task automatic test_stall();
    cap1 = '0;
    run_d1(1'b1);
    n_cmp++; if (hs_n != 4) begin n_bad++; $display("FAIL stall.handshakes got=%0d exp=4", hs_n); end
    n_cmp++; if (en_n != 64) begin n_bad++; $display("FAIL stall.en_cycles got=%0d exp=64", en_n); end
    n_cmp++; if (first_en != 2 || last_en != 70) begin n_bad++; $display("FAIL stall.en_window got=%0d..%0d exp=2..70", first_en, last_en); end
    n_cmp++; if (gap_at != 34) begin n_bad++; $display("FAIL stall.first_gap got=%0d exp=34", gap_at); end
    n_cmp++; if (done_at != 71 || done_n != 1) begin n_bad++; $display("FAIL stall.done got=cycle %0d x%0d exp=cycle 71 x1", done_at, done_n); end
    n_cmp++; if (cap1 !== 64'h0008000400020001) begin n_bad++; $display("FAIL stall.lut_contents got=%h exp=0008000400020001", cap1); end
  endtask
  task automatic test_chunk4();
    logic [15:0] exp_seq = 16'hF0A5;
    logic [15:0] got = '0;
    int n = 0, first = 0, dat = 0;
    bit taken = 0;
    @(negedge clk);
    wd2 = 32'h0000F0A5;
    wv2 = 1'b1;
    s2 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      s2 = 1'b0;
      if (taken) wv2 = 1'b0;
      taken = wv2 && wr2;
      if (ce2[0]) begin
        if (n < 4) got[4*n +: 4] = cd2;
        if (first == 0) first = i;
        n++;
      end
      if (done2) dat = i;
    end
    n_cmp++; if (n != 4) begin n_bad++; $display("FAIL cw4.en_cycles got=%0d exp=4", n); end
    n_cmp++; if (got !== exp_seq) begin n_bad++; $display("FAIL cw4.chunk_seq got=%h exp=%h", got, exp_seq); end
    n_cmp++; if (first != 2 || dat != 6) begin n_bad++; $display("FAIL cw4.timing got=first %0d done %0d exp=first 2 done 6", first, dat); end
    n_cmp++; if (cap2 !== 16'hF0A5) begin n_bad++; $display("FAIL cw4.lut_contents got=%h exp=f0a5", cap2); end
  endtask
  task automatic test_reset_mid();
    bit taken = 0;
    wd0 = 32'h0000A5C3;
    wv0 = 1'b1;
    @(negedge clk);
    s0 = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      s0 = 1'b0;
      if (taken) wv0 = 1'b0;
      taken = wv0 && wr0;
    end
    wv0 = 1'b0;
    n_cmp++; if (ce0 !== 1'b1 || cd0 !== 1'b1) begin n_bad++; $display("FAIL rstmid.pre got=en %b data %b exp=en 1 data 1", ce0, cd0); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (ce0 !== 1'b0 || cd0 !== 1'b0) begin n_bad++; $display("FAIL rstmid.chain got=en %b data %b exp=0 0", ce0, cd0); end
    n_cmp++; if (busy0 !== 1'b0 || done0 !== 1'b0 || wr0 !== 1'b0) begin n_bad++; $display("FAIL rstmid.status got=busy %b done %b ready %b exp=0 0 0", busy0, done0, wr0); end
    #1 rst_n = 1'b1;
    run_d0(32'h00005A3C, 0, 1'b0);
    n_cmp++; if (en_n != 16 || done_at != 18 || done_n != 1) begin n_bad++; $display("FAIL rstmid.reload got=en %0d done cycle %0d x%0d exp=16 18 1", en_n, done_at, done_n); end
    n_cmp++; if (cap0 !== 16'h5A3C) begin n_bad++; $display("FAIL rstmid.lut_contents got=%h exp=5a3c", cap0); end
  endtask
  task automatic test_restart();
    run_d0(32'h00001234, 4, 1'b1);
    n_cmp++; if (idle_rdy != 0) begin n_bad++; $display("FAIL restart.idle_ready got=%0d exp=0", idle_rdy); end
    n_cmp++; if (hs_n != 1) begin n_bad++; $display("FAIL restart.handshakes got=%0d exp=1", hs_n); end
    n_cmp++; if (done_n != 1 || done_at != 18) begin n_bad++; $display("FAIL restart.done got=cycle %0d x%0d exp=cycle 18 x1", done_at, done_n); end
    n_cmp++; if (en_n != 16) begin n_bad++; $display("FAIL restart.en_cycles got=%0d exp=16", en_n); end
    n_cmp++; if (cap0 !== 16'h1234) begin n_bad++; $display("FAIL restart.lut_contents got=%h exp=1234", cap0); end
  endtask
  initial begin
    test_reset();
    test_default();
    test_back_to_back();
    test_stall();
    test_chunk4();
    test_reset_mid();
    test_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
